block_deserializer: RTL and testbench
=====================================

BLOCK_DESERIALIZER -- requirements
Module: block_deserializer

Interface
REQ-001 Parameter N, default 1: maximum number of trace blocks presented per cycle by the block producer.
REQ-002 Parameter FIFO_DEPTH, default 16: block buffer entries; SHALL be a power of two and >= N.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 valid_i  in  N  per-lane block valid; lane 0 is oldest.
REQ-006 iretire_i  in  N x mure_pkg::IRETIRE_LEN  halfwords retired per block.
REQ-007 ilastsize_i  in  N  last instruction size: 0 = 2 bytes, 1 = 4 bytes.
REQ-008 itype_i  in  N x mure_pkg::ITYPE_LEN  block type; 1 = exception, 2 = interrupt.
REQ-009 iaddr_i  in  N x mure_pkg::XLEN  address of the first instruction in the block.
REQ-010 cause_i, tval_i  in  mure_pkg::CAUSE_LEN, mure_pkg::XLEN  trap info; applies to lane 0 only.
REQ-011 priv_i  in  mure_pkg::PRIV_LEN  privilege level; shared by all lanes that cycle.
REQ-012 ready_i  in  1  downstream accepts the head block.
REQ-013 clear_i  in  1  synchronous clear of overflow_o.
REQ-014 valid_o  out  1  head block available.
REQ-015 iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o  out  same widths as inputs  head block fields.
REQ-016 last_addr_o  out  mure_pkg::XLEN  address of the last instruction in the head block.
REQ-017 overflow_o  out  1  sticky flag: a cycle of input blocks was dropped.
REQ-018 err_o  out  1  protocol error pulse (see Configuration).

Function
REQ-019 The block SHALL write each valid lane, in ascending lane order, into a circular buffer of FIFO_DEPTH entries; invalid lanes SHALL be skipped without leaving gaps.
REQ-020 Each entry SHALL store iaddr, iretire, ilastsize, itype and priv; it SHALL store cause/tval only for the lane 0 entry with itype 1 or 2, and zeros otherwise.
REQ-021 Writes SHALL be all-or-nothing: if popcount(valid_i) exceeds free entries (occupancy before this cycle's pop), no lane SHALL be written and overflow_o SHALL set on the next edge.
REQ-022 overflow_o SHALL stay set until clear_i is sampled high; a set event in the same cycle as clear_i SHALL win.
REQ-023 valid_o SHALL equal "buffer not empty"; head fields SHALL be driven combinationally from the read pointer and SHALL be 0 when empty.
REQ-024 The head SHALL pop on valid_o && ready_i; push and pop in the same cycle SHALL both take effect.
REQ-025 Latency: a block written at edge k SHALL be visible on valid_o in cycle k+1 at the earliest; there is no input-to-output bypass.
REQ-026 last_addr_o SHALL be iaddr + 2*iretire - (ilastsize ? 4 : 2), computed modulo 2^XLEN.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be $clog2(FIFO_DEPTH)+1 bits wide and SHALL reach exactly FIFO_DEPTH when full.
REQ-028 Output order SHALL equal arrival order (cycle order, then lane order).

Reset
REQ-029 On reset: pointers and occupancy SHALL be 0; valid_o, overflow_o and err_o SHALL be 0; all head fields SHALL read 0.
REQ-030 A reset asserted mid-operation SHALL discard all buffered blocks immediately, without draining them.

Configuration
REQ-031 With MURE_BLKDES_CHECK_EN defined, err_o SHALL pulse for one cycle, one cycle after any of these input conditions: a valid lane with iretire == 0; valid lanes that are non-contiguous (lane i valid while lane i-1 invalid); itype 1 or 2 on a lane other than 0.
REQ-032 Without MURE_BLKDES_CHECK_EN, err_o SHALL be tied to 0 and the checking logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The block entry struct (blk_entry_s) SHALL be defined in mure_pkg; the widths SHALL be the existing mure_pkg constants.
REQ-034 Storage SHALL be a single sub-module, blk_buffer: an N-write, 1-read circular buffer with occupancy output.

Verification
REQ-035 N=2: valid_i=2'b11, iaddr={0x1008, 0x1000}, iretire={4, 6}, ilastsize={1, 0}, ready_i=1 -> next cycle iaddr_o=0x1000 with last_addr_o=0x100A, then iaddr_o=0x1008 with last_addr_o=0x100C.
REQ-036 Lane 0 with itype=1, cause=0x2, tval=0xDEAD -> output carries cause_o=0x2, tval_o=0xDEAD; the following non-trap block carries cause_o=0, tval_o=0.
REQ-037 ready_i=0 and FIFO_DEPTH=16: push 8 cycles of 2 blocks, then 1 more -> overflow_o=1, occupancy stays 16; pulsing clear_i -> overflow_o=0; draining yields exactly 16 blocks in order.
REQ-038 Full buffer with push of 1 block and pop of 1 in the same cycle -> push rejected and overflow_o=1; occupancy becomes 15.
REQ-039 Reset asserted with 5 buffered blocks -> valid_o=0 asynchronously; after release, with no new input, nothing is emitted.
REQ-040 With MURE_BLKDES_CHECK_EN: valid_i=2'b10 -> err_o=1 for one cycle; iretire=0 on lane 0 -> err_o=1; without the macro both cases -> err_o=0.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared trace-encoder constants, the buffered block entry type and small helpers.
// Used by block_deserializer, its interface and its storage sub-module.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 8;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT = ITYPE_LEN'(2);

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [PRIV_LEN-1:0]    priv;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
    } blk_entry_s;

    function automatic logic is_trap(input logic [ITYPE_LEN-1:0] t);
        return (t == ITYPE_EXC) || (t == ITYPE_INT);
    endfunction

    // iretire counts halfwords; back off by the size of the final instruction.
    function automatic logic [XLEN-1:0] last_addr(input blk_entry_s e);
        return e.iaddr + (XLEN'(e.iretire) << 1) - (e.ilastsize ? XLEN'(4) : XLEN'(2));
    endfunction

endpackage

// File: rtl/block_deserializer_if.sv
// Producer-side and consumer-side bus of block_deserializer.
// master = block producer / downstream consumer, slave = the deserializer.
interface block_deserializer_if
    import mure_pkg::*;
#(
    parameter int N = 1
);
    logic [N-1:0]                  valid_i;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]                  ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
    logic [N-1:0][XLEN-1:0]        iaddr_i;
    logic [CAUSE_LEN-1:0]          cause_i;
    logic [XLEN-1:0]               tval_i;
    logic [PRIV_LEN-1:0]           priv_i;
    logic                          ready_i;
    logic                          clear_i;

    logic                          valid_o;
    logic [IRETIRE_LEN-1:0]        iretire_o;
    logic                          ilastsize_o;
    logic [ITYPE_LEN-1:0]          itype_o;
    logic [XLEN-1:0]               iaddr_o;
    logic [CAUSE_LEN-1:0]          cause_o;
    logic [XLEN-1:0]               tval_o;
    logic [PRIV_LEN-1:0]           priv_o;
    logic [XLEN-1:0]               last_addr_o;
    logic                          overflow_o;
    logic                          err_o;

    modport master (
        output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
               cause_i, tval_i, priv_i, ready_i, clear_i,
        input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o,
               cause_o, tval_o, priv_o, last_addr_o, overflow_o, err_o
    );

    modport slave (
        input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
               cause_i, tval_i, priv_i, ready_i, clear_i,
        output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o,
               cause_o, tval_o, priv_o, last_addr_o, overflow_o, err_o
    );

endinterface

// File: rtl/block_deserializer_buffer.sv
// blk_buffer: N-write / 1-read circular buffer of trace blocks with occupancy output.
// A write cycle is all-or-nothing; drop_o flags a rejected cycle.
module blk_buffer
    import mure_pkg::*;
#(
    parameter int N     = 1,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N-1:0]           lane_valid_i,
    input  blk_entry_s [N-1:0]     wr_data_i,
    input  logic                   pop_i,
    output blk_entry_s             rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    blk_entry_s    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_slot [N];
    logic [CW-1:0] w_nvalid;
    logic          w_fits;
    logic          w_push;

    // Each valid lane lands at wptr + (number of valid lanes below it), so gaps collapse.
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < N; i++) begin
            w_slot[i] = r_wptr + w_nvalid[AW-1:0];
            if (lane_valid_i[i]) begin
                w_nvalid = w_nvalid + CW'(1);
            end
        end
    end

    assign w_fits = w_nvalid <= (CW'(DEPTH) - r_count);
    assign w_push = (|lane_valid_i) && w_fits;
    assign drop_o = (|lane_valid_i) && !w_fits;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int i = 0; i < N; i++) begin
                if (lane_valid_i[i]) begin
                    r_mem[w_slot[i]] <= wr_data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_nvalid[AW-1:0];
            end
            if (pop_i) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (w_push ? w_nvalid : CW'(0)) - (pop_i ? CW'(1) : CW'(0));
        end
    end

    assign rd_data_o = r_mem[r_rptr];
    assign count_o   = r_count;

endmodule

// File: rtl/block_deserializer.sv
// Collects up to N trace blocks per cycle into a FIFO and presents them one at a time.
// Define MURE_BLKDES_CHECK_EN to enable the input protocol checker driving err_o.
module block_deserializer
    import mure_pkg::*;
#(
    parameter int N          = 1,
    parameter int FIFO_DEPTH = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    block_deserializer_if.slave bus
);
    blk_entry_s [N-1:0]          w_entries;
    blk_entry_s                  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_valid;
    logic                        w_pop;
    logic                        w_drop;
    logic                        r_overflow;

    // Trap info only travels with a lane 0 exception/interrupt block.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_entries[i]           = '0;
            w_entries[i].iaddr     = bus.iaddr_i[i];
            w_entries[i].iretire   = bus.iretire_i[i];
            w_entries[i].ilastsize = bus.ilastsize_i[i];
            w_entries[i].itype     = bus.itype_i[i];
            w_entries[i].priv      = bus.priv_i;
            if (i == 0 && is_trap(bus.itype_i[i])) begin
                w_entries[i].cause = bus.cause_i;
                w_entries[i].tval  = bus.tval_i;
            end
        end
    end

    blk_buffer #(
        .N     (N),
        .DEPTH (FIFO_DEPTH)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lane_valid_i (bus.valid_i),
        .wr_data_i    (w_entries),
        .pop_i        (w_pop),
        .rd_data_o    (w_head),
        .count_o      (w_count),
        .drop_o       (w_drop)
    );

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && bus.ready_i;

    assign bus.valid_o     = w_valid;
    assign bus.iaddr_o     = w_valid ? w_head.iaddr     : '0;
    assign bus.iretire_o   = w_valid ? w_head.iretire   : '0;
    assign bus.ilastsize_o = w_valid ? w_head.ilastsize : 1'b0;
    assign bus.itype_o     = w_valid ? w_head.itype     : '0;
    assign bus.priv_o      = w_valid ? w_head.priv      : '0;
    assign bus.cause_o     = w_valid ? w_head.cause     : '0;
    assign bus.tval_o      = w_valid ? w_head.tval      : '0;
    assign bus.last_addr_o = w_valid ? last_addr(w_head) : '0;

    // A drop in the same cycle as clear keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clear_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.overflow_o = r_overflow;

`ifdef MURE_BLKDES_CHECK_EN
    logic w_err_cond;
    logic r_err;

    always_comb begin
        w_err_cond = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.valid_i[i] && bus.iretire_i[i] == '0) begin
                w_err_cond = 1'b1;
            end
        end
        for (int i = 1; i < N; i++) begin
            if (bus.valid_i[i] && (!bus.valid_i[i-1] || is_trap(bus.itype_i[i]))) begin
                w_err_cond = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_cond;
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_block_deserializer.sv
// Directed self-checking bench for block_deserializer with N=2, FIFO_DEPTH=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_block_deserializer;
    import mure_pkg::*;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;
    logic expErr;

    block_deserializer_if #(.N(2)) bus();

    block_deserializer #(
        .N          (2),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.valid_i     = '0;
        bus.iretire_i   = '0;
        bus.ilastsize_i = '0;
        bus.itype_i     = '0;
        bus.iaddr_i     = '0;
        bus.cause_i     = '0;
        bus.tval_i      = '0;
        bus.priv_i      = '0;
        bus.ready_i     = 1'b0;
        bus.clear_i     = 1'b0;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] addr, input logic [7:0] ret,
                            input logic lsize, input logic [2:0] ty);
        bus.valid_i[lane]     = 1'b1;
        bus.iaddr_i[lane]     = addr;
        bus.iretire_i[lane]   = ret;
        bus.ilastsize_i[lane] = lsize;
        bus.itype_i[lane]     = ty;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        nCompared += 5;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %0b want 0", bus.valid_o); end
        if (bus.overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow got %0b want 0", bus.overflow_o); end
        if (bus.err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err got %0b want 0", bus.err_o); end
        if (bus.iaddr_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_iaddr got %h want 0", bus.iaddr_o); end
        if (bus.last_addr_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_last_addr got %h want 0", bus.last_addr_o); end
        rst_n = 1'b1;
        @(negedge clk);
        nCompared++;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_valid got %0b want 0", bus.valid_o); end
    endtask

    task automatic test_two_lanes();
        @(negedge clk);
        clear_inputs();
        set_lane(0, 32'h1000, 8'd6, 1'b0, 3'd0);
        set_lane(1, 32'h1008, 8'd4, 1'b1, 3'd0);
        bus.ready_i = 1'b1;
        #1;
        nCompared++;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL no_bypass got %0b want 0", bus.valid_o); end
        @(negedge clk);
        bus.valid_i = '0;
        nCompared += 5;
        if (bus.valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL lane0_valid got %0b want 1", bus.valid_o); end
        if (bus.iaddr_o !== 32'h1000) begin nMismatched++; $display("[TB] FAIL lane0_iaddr got %h want 1000", bus.iaddr_o); end
        if (bus.last_addr_o !== 32'h100A) begin nMismatched++; $display("[TB] FAIL lane0_last got %h want 100a", bus.last_addr_o); end
        if (bus.iretire_o !== 8'd6) begin nMismatched++; $display("[TB] FAIL lane0_iretire got %0d want 6", bus.iretire_o); end
        if (bus.ilastsize_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL lane0_lastsize got %0b want 0", bus.ilastsize_o); end
        @(negedge clk);
        nCompared += 3;
        if (bus.iaddr_o !== 32'h1008) begin nMismatched++; $display("[TB] FAIL lane1_iaddr got %h want 1008", bus.iaddr_o); end
        if (bus.last_addr_o !== 32'h100C) begin nMismatched++; $display("[TB] FAIL lane1_last got %h want 100c", bus.last_addr_o); end
        if (bus.ilastsize_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL lane1_lastsize got %0b want 1", bus.ilastsize_o); end
        @(negedge clk);
        nCompared += 2;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL empty_valid got %0b want 0", bus.valid_o); end
        if (bus.iaddr_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL empty_iaddr got %h want 0", bus.iaddr_o); end
    endtask

    task automatic test_trap();
        @(negedge clk);
        clear_inputs();
        set_lane(0, 32'h2000, 8'd3, 1'b1, 3'd1);
        bus.cause_i = 5'h2;
        bus.tval_i  = 32'hDEAD;
        bus.priv_i  = 2'd3;
        bus.ready_i = 1'b1;
        @(negedge clk);
        set_lane(0, 32'h2010, 8'd2, 1'b0, 3'd0);
        nCompared += 5;
        if (bus.iaddr_o !== 32'h2000) begin nMismatched++; $display("[TB] FAIL trap_iaddr got %h want 2000", bus.iaddr_o); end
        if (bus.cause_o !== 5'h2) begin nMismatched++; $display("[TB] FAIL trap_cause got %h want 2", bus.cause_o); end
        if (bus.tval_o !== 32'hDEAD) begin nMismatched++; $display("[TB] FAIL trap_tval got %h want dead", bus.tval_o); end
        if (bus.itype_o !== 3'd1) begin nMismatched++; $display("[TB] FAIL trap_itype got %0d want 1", bus.itype_o); end
        if (bus.priv_o !== 2'd3) begin nMismatched++; $display("[TB] FAIL trap_priv got %0d want 3", bus.priv_o); end
        @(negedge clk);
        bus.valid_i = '0;
        nCompared += 3;
        if (bus.iaddr_o !== 32'h2010) begin nMismatched++; $display("[TB] FAIL plain_iaddr got %h want 2010", bus.iaddr_o); end
        if (bus.cause_o !== 5'h0) begin nMismatched++; $display("[TB] FAIL plain_cause got %h want 0", bus.cause_o); end
        if (bus.tval_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL plain_tval got %h want 0", bus.tval_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clear_inputs();
            set_lane(0, 32'h3000 + 32'(8 * k), 8'd1, 1'b0, 3'd0);
            set_lane(1, 32'h3004 + 32'(8 * k), 8'd1, 1'b0, 3'd0);
        end
        @(negedge clk);
        set_lane(0, 32'h9990, 8'd1, 1'b0, 3'd0);
        set_lane(1, 32'h9994, 8'd1, 1'b0, 3'd0);
        nCompared++;
        if (bus.overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_no_overflow got %0b want 0", bus.overflow_o); end
        @(negedge clk);
        bus.clear_i = 1'b1;
        nCompared++;
        if (bus.overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL overflow_set got %0b want 1", bus.overflow_o); end
        @(negedge clk);
        bus.valid_i = '0;
        nCompared++;
        if (bus.overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL set_beats_clear got %0b want 1", bus.overflow_o); end
        @(negedge clk);
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b1;
        nCompared++;
        if (bus.overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL overflow_clear got %0b want 0", bus.overflow_o); end
        for (int k = 0; k < 16; k++) begin
            nCompared += 2;
            if (bus.valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_valid[%0d] got %0b want 1", k, bus.valid_o); end
            if (bus.iaddr_o !== 32'h3000 + 32'(4 * k)) begin
                nMismatched++; $display("[TB] FAIL drain_iaddr[%0d] got %h want %h", k, bus.iaddr_o, 32'h3000 + 32'(4 * k));
            end
            @(negedge clk);
        end
        nCompared++;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_end_valid got %0b want 0", bus.valid_o); end
        clear_inputs();
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clear_inputs();
            set_lane(0, 32'h4000 + 32'(8 * k), 8'd1, 1'b0, 3'd0);
            set_lane(1, 32'h4004 + 32'(8 * k), 8'd1, 1'b0, 3'd0);
        end
        @(negedge clk);
        clear_inputs();
        set_lane(0, 32'h5000, 8'd1, 1'b0, 3'd0);
        bus.ready_i = 1'b1;
        nCompared += 2;
        if (bus.overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL pp_pre_overflow got %0b want 0", bus.overflow_o); end
        if (bus.iaddr_o !== 32'h4000) begin nMismatched++; $display("[TB] FAIL pp_head got %h want 4000", bus.iaddr_o); end
        @(negedge clk);
        bus.valid_i = '0;
        nCompared++;
        if (bus.overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL pp_overflow got %0b want 1", bus.overflow_o); end
        for (int k = 1; k < 16; k++) begin
            nCompared++;
            if (bus.iaddr_o !== 32'h4000 + 32'(4 * k)) begin
                nMismatched++; $display("[TB] FAIL pp_drain[%0d] got %h want %h", k, bus.iaddr_o, 32'h4000 + 32'(4 * k));
            end
            @(negedge clk);
        end
        bus.clear_i = 1'b1;
        nCompared++;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL pp_end_valid got %0b want 0", bus.valid_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_inputs();
        set_lane(0, 32'h7000, 8'd1, 1'b0, 3'd0);
        set_lane(1, 32'h7004, 8'd1, 1'b0, 3'd0);
        @(negedge clk);
        set_lane(0, 32'h7008, 8'd1, 1'b0, 3'd0);
        set_lane(1, 32'h700C, 8'd1, 1'b0, 3'd0);
        @(negedge clk);
        bus.valid_i = 2'b01;
        bus.iaddr_i[0] = 32'h7010;
        @(negedge clk);
        bus.valid_i = '0;
        nCompared++;
        if (bus.valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_pre_valid got %0b want 1", bus.valid_o); end
        #2 rst_n = 1'b0;
        #1;
        nCompared += 2;
        if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_async_valid got %0b want 0", bus.valid_o); end
        if (bus.iaddr_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_async_iaddr got %h want 0", bus.iaddr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nCompared++;
            if (bus.valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_after_valid[%0d] got %0b want 0", k, bus.valid_o); end
        end
        clear_inputs();
    endtask

    task automatic test_err();
`ifdef MURE_BLKDES_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        @(negedge clk);
        clear_inputs();
        bus.ready_i = 1'b1;
        set_lane(1, 32'h6000, 8'd2, 1'b0, 3'd0);
        bus.valid_i[0] = 1'b0;
        @(negedge clk);
        bus.valid_i = '0;
        nCompared++;
        if (bus.err_o !== expErr) begin nMismatched++; $display("[TB] FAIL err_gap got %0b want %0b", bus.err_o, expErr); end
        @(negedge clk);
        set_lane(0, 32'h6010, 8'd0, 1'b0, 3'd0);
        nCompared++;
        if (bus.err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_pulse_end got %0b want 0", bus.err_o); end
        @(negedge clk);
        set_lane(0, 32'h6020, 8'd2, 1'b0, 3'd0);
        set_lane(1, 32'h6028, 8'd2, 1'b0, 3'd2);
        nCompared++;
        if (bus.err_o !== expErr) begin nMismatched++; $display("[TB] FAIL err_zero_retire got %0b want %0b", bus.err_o, expErr); end
        @(negedge clk);
        set_lane(1, 32'h6030, 8'd2, 1'b0, 3'd0);
        nCompared++;
        if (bus.err_o !== expErr) begin nMismatched++; $display("[TB] FAIL err_trap_lane1 got %0b want %0b", bus.err_o, expErr); end
        @(negedge clk);
        bus.valid_i = '0;
        nCompared++;
        if (bus.err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_clean got %0b want 0", bus.err_o); end
        repeat (6) @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_two_lanes();
        test_trap();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
